// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: FSM encoding, iteration-count width and default code size.
// Used by the decoder and by the matching encoder.
package ldpc_pkg;

  localparam int unsigned IterW    = 8;
  localparam int unsigned DefaultN = 6;
  localparam int unsigned DefaultK = 3;

  typedef logic [1:0]       state_t;
  typedef logic [IterW-1:0] iter_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StSynd = 2'd1;
  localparam state_t StEval = 2'd2;
  localparam state_t StDone = 2'd3;

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome: s[r] = XOR over c of H[r][c] & word[c], H row-major in parity_h_i.
module ldpc_syndrome
  import ldpc_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned K = DefaultK
) (
  input  logic [N-1:0]       word_i,
  input  logic [(N-K)*N-1:0] parity_h_i,
  output logic [N-K-1:0]     syndrome_o
);

  always_comb begin
    syndrome_o = '0;
    for (int r = 0; r < int'(N - K); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        syndrome_o[r] = syndrome_o[r] ^ (word_i[c] & parity_h_i[r*N+c]);
      end
    end
  end

endmodule

// File: rtl/ldpc_decode.sv
// Hard-decision bit-flip LDPC decoder: flips every bit touching the most unsatisfied checks
// until the syndrome clears, the iteration budget runs out, or no bit is implicated.
module ldpc_decode
  import ldpc_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned K        = DefaultK,
  parameter int unsigned MAX_ITER = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N-1:0]       rx_bits,
  input  logic [(N-K)*N-1:0] parity_h,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N-1:0]       o_codeword,
  output logic [K-1:0]       o_info,
  output logic               o_success,
  output logic [IterW-1:0]   o_iters
);

  localparam int unsigned M    = N - K;
  localparam int unsigned CntW = $clog2(M + 1);
  localparam iter_t       MaxIter = IterW'(MAX_ITER);

  state_t        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic [M-1:0]  syn_q, syn_d;
  iter_t         iter_q, iter_d;
  logic [N-1:0]  cw_q, cw_d;
  logic          succ_q, succ_d;
  iter_t         iters_q, iters_d;

  logic [M-1:0]    syn_comb;
  logic [CntW-1:0] col_cnt [N];
  logic [CntW-1:0] max_cnt;
  logic [N-1:0]    flip_mask;

  ldpc_syndrome #(
    .N (N),
    .K (K)
  ) u_syndrome (
    .word_i     (word_q),
    .parity_h_i (parity_h),
    .syndrome_o (syn_comb)
  );

  // Per-bit count of unsatisfied checks and the set of bits sharing the maximum.
  always_comb begin
    max_cnt   = '0;
    flip_mask = '0;
    for (int c = 0; c < int'(N); c++) begin
      col_cnt[c] = '0;
      for (int r = 0; r < int'(M); r++) begin
        col_cnt[c] = col_cnt[c] + CntW'(syn_q[r] & parity_h[r*N+c]);
      end
      if (col_cnt[c] > max_cnt) begin
        max_cnt = col_cnt[c];
      end
    end
    for (int c = 0; c < int'(N); c++) begin
      flip_mask[c] = (max_cnt != '0) && (col_cnt[c] == max_cnt);
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    syn_d   = syn_q;
    iter_d  = iter_q;
    cw_d    = cw_q;
    succ_d  = succ_q;
    iters_d = iters_q;
    case (state_q)
      StIdle: begin
        if (i_valid) begin
          word_d  = rx_bits;
          iter_d  = '0;
          state_d = StSynd;
        end
      end
      StSynd: begin
        syn_d   = syn_comb;
        state_d = StEval;
      end
      StEval: begin
        if (syn_q == '0) begin
          cw_d    = word_q;
          succ_d  = 1'b1;
          iters_d = iter_q;
          state_d = StDone;
        end else if ((iter_q == MaxIter) || (max_cnt == '0)) begin
          cw_d    = word_q;
          succ_d  = 1'b0;
          iters_d = iter_q;
          state_d = StDone;
        end else begin
          word_d  = word_q ^ flip_mask;
          iter_d  = iter_q + 1'b1;
          state_d = StSynd;
        end
      end
      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      syn_q   <= '0;
      iter_q  <= '0;
      cw_q    <= '0;
      succ_q  <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      syn_q   <= syn_d;
      iter_q  <= iter_d;
      cw_q    <= cw_d;
      succ_q  <= succ_d;
      iters_q <= iters_d;
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = (state_q == StDone);
  assign o_codeword = cw_q;
  assign o_info     = cw_q[K-1:0];
  assign o_success  = succ_q;
  assign o_iters    = iters_q;

endmodule
